// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the registered carry-lookahead adder.
//   GROUP_W : width of one first-level lookahead group (fixed at 4 bits)
//   pg_t    : propagate/generate pair summarising one group
// No ports; imported by the lookahead block and the adder top.
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;

    // Group summary: p = every bit of the group propagates,
    // g = the group produces a carry on its own regardless of carry in.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage

// File: rtl/cla_if.sv
// -----------------------------------------------------------------------------
// cla_if
// Operand/result bundle for the carry-lookahead adder.
//   a, b     : operands, unsigned, WIDTH bits        (master -> slave)
//   cin      : carry in                              (master -> slave)
//   s        : registered sum, WIDTH bits            (slave -> master)
//   cout     : registered carry out                  (slave -> master)
//   grp_p    : registered whole-word propagate       (slave -> master)
//   grp_g    : registered whole-word generate        (slave -> master)
// The adder is the slave; whoever supplies operands is the master.
// -----------------------------------------------------------------------------
interface cla_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             grp_p;
    logic             grp_g;

    modport master (
        output a, b, cin,
        input  s, cout, grp_p, grp_g
    );

    modport slave (
        input  a, b, cin,
        output s, cout, grp_p, grp_g
    );

endinterface

// File: rtl/cla_block4.sv
// -----------------------------------------------------------------------------
// cla_block4
// Purely combinational 4-bit carry-lookahead unit.
//   a_i, b_i : 4-bit operand slices
//   c_i      : carry into this group
//   s_o      : 4-bit sum slice
//   pg_o     : group propagate/generate summary
// Internal carries are flat sum-of-products of g/p/c_i, so there is no ripple
// path through the group. The group P/G outputs never depend on c_i, which is
// what lets the second-level unit compute every group's carry in parallel.
// -----------------------------------------------------------------------------
module cla_block4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               c_i,
    output logic [GROUP_W-1:0] s_o,
    output pg_t                pg_o
);

    logic [GROUP_W-1:0] bitProp;
    logic [GROUP_W-1:0] bitGen;
    logic [GROUP_W-1:0] bitCarry;

    // Per-bit propagate and generate terms.
    assign bitProp = a_i ^ b_i;
    assign bitGen  = a_i & b_i;

    // Carries into bits 1..3, each written out in full rather than chained
    // from the previous carry, so every one is two gate levels from g/p.
    assign bitCarry[0] = c_i;
    assign bitCarry[1] = bitGen[0]
                       | (bitProp[0] & c_i);
    assign bitCarry[2] = bitGen[1]
                       | (bitProp[1] & bitGen[0])
                       | (bitProp[1] & bitProp[0] & c_i);
    assign bitCarry[3] = bitGen[2]
                       | (bitProp[2] & bitGen[1])
                       | (bitProp[2] & bitProp[1] & bitGen[0])
                       | (bitProp[2] & bitProp[1] & bitProp[0] & c_i);

    assign s_o = bitProp ^ bitCarry;

    // Group summary handed up to the second-level lookahead. The carry out of
    // this group is rebuilt there as G | P & c_i.
    assign pg_o.p = &bitProp;
    assign pg_o.g = bitGen[3]
                  | (bitProp[3] & bitGen[2])
                  | (bitProp[3] & bitProp[2] & bitGen[1])
                  | (bitProp[3] & bitProp[2] & bitProp[1] & bitGen[0]);

endmodule

// File: rtl/cla.sv
// -----------------------------------------------------------------------------
// cla
// Registered carry-lookahead adder: {cout, s} = a + b + cin, one cycle latency.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every output immediately
//   bus    : cla_if slave port (a, b, cin in; s, cout, grp_p, grp_g out)
// Parameter WIDTH must be a positive multiple of 4. The word is split into
// WIDTH/4 cla_block4 groups; a second-level lookahead builds each group's
// carry in directly from the group P/G summaries and cin. A new operand set is
// accepted every cycle with no handshake.
// -----------------------------------------------------------------------------
module cla
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    cla_if.slave  bus
);

    localparam int NumGroups = WIDTH / GROUP_W;

    // Reject widths the group structure cannot tile exactly.
    if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_widthCheck
        $error("cla: WIDTH must be a positive multiple of 4");
    end

    logic [NumGroups-1:0] grpProp;
    logic [NumGroups-1:0] grpGen;
    logic [NumGroups:0]   grpCarry;
    logic [WIDTH-1:0]     sum_d;
    logic                 carryOut_d;
    logic                 wordProp_d;
    logic                 wordGen_d;
    logic [WIDTH-1:0]     sum_q;
    logic                 carryOut_q;
    logic                 wordProp_q;
    logic                 wordGen_q;

    // Carry into group k as a flat sum-of-products:
    //   G[k-1] | P[k-1]G[k-2] | ... | P[k-1]..P[0]cin
    // The loops unroll into independent product terms, so no term waits on
    // another group's carry. With cIn tied low and k = NumGroups this is the
    // whole-word generate.
    function automatic logic carryInto(
        input logic [NumGroups-1:0] gp,
        input logic [NumGroups-1:0] gg,
        input logic                 cIn,
        input int                   k
    );
        logic acc;
        logic term;
        acc = cIn;
        for (int m = 0; m < k; m++) begin
            acc = acc & gp[m];
        end
        for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) begin
                term = term & gp[m];
            end
            acc = acc | term;
        end
        return acc;
    endfunction

    // One lookahead block per 4-bit slice. Each block's P/G depends only on
    // its operand bits; its sum uses the carry delivered by the second level.
    for (genvar k = 0; k < NumGroups; k++) begin : g_group
        pg_t groupPg;

        cla_block4 u_block4 (
            .a_i  (bus.a[k*GROUP_W +: GROUP_W]),
            .b_i  (bus.b[k*GROUP_W +: GROUP_W]),
            .c_i  (grpCarry[k]),
            .s_o  (sum_d[k*GROUP_W +: GROUP_W]),
            .pg_o (groupPg)
        );

        assign grpProp[k] = groupPg.p;
        assign grpGen[k]  = groupPg.g;
    end

    // Second-level lookahead: every group carry, including the final carry
    // out, computed side by side from the group summaries and cin.
    for (genvar k = 0; k <= NumGroups; k++) begin : g_carry
        assign grpCarry[k] = carryInto(grpProp, grpGen, bus.cin, k);
    end

    assign carryOut_d = grpCarry[NumGroups];
    assign wordProp_d = &grpProp;
    assign wordGen_d  = carryInto(grpProp, grpGen, 1'b0, NumGroups);

    // Output register. Reset clears everything at once and throws away any
    // sum computed from the operands present when reset arrived; the first
    // capture after release happens on the next rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carryOut_q <= 1'b0;
            wordProp_q <= 1'b0;
            wordGen_q  <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carryOut_q <= carryOut_d;
            wordProp_q <= wordProp_d;
            wordGen_q  <= wordGen_d;
        end
    end

    assign bus.s     = sum_q;
    assign bus.cout  = carryOut_q;
    assign bus.grp_p = wordProp_q;
    assign bus.grp_g = wordGen_q;

endmodule

// File: tb/tb_cla.sv
// -----------------------------------------------------------------------------
// tb_cla
// Directed self-checking bench for the 4-bit registered carry-lookahead adder.
// Each task drives one scenario and checks the registered outputs 1 ns after
// the capturing edge. Expected values are hand-computed, except the full sweep
// which compares against a + b + cin evaluated by the bench.
// -----------------------------------------------------------------------------
module tb_cla;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    cla_if #(.WIDTH(W)) bus ();

    cla #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock; first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one operand set away from the rising edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    // Reset asserted with nonzero operands: outputs are zero before any edge.
    task automatic test_reset();
        rst_n   = 1'b0;
        bus.a   = 4'hF;
        bus.b   = 4'hF;
        bus.cin = 1'b0;
        #2;
        testsRun++;
        if ({bus.cout, bus.s, bus.grp_p, bus.grp_g} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: got cout=%b s=%b p=%b g=%b, want all 0",
                     bus.cout, bus.s, bus.grp_p, bus.grp_g);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if ({bus.cout, bus.s, bus.grp_p, bus.grp_g} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_held: got cout=%b s=%b p=%b g=%b, want all 0",
                     bus.cout, bus.s, bus.grp_p, bus.grp_g);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One vector through the pipeline with a hand-computed expectation.
    task automatic checkVector(input string name,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] expS, input logic expC,
                               input logic expP, input logic expG);
        applyStimulus(a, b, cin);
        @(posedge clk);
        #1;
        testsRun++;
        if ({bus.cout, bus.s, bus.grp_p, bus.grp_g} !== {expC, expS, expP, expG}) begin
            testsFailed++;
            $display("[TB] FAIL %s: got cout=%b s=%b p=%b g=%b, want cout=%b s=%b p=%b g=%b",
                     name, bus.cout, bus.s, bus.grp_p, bus.grp_g, expC, expS, expP, expG);
        end
    endtask

    task automatic test_no_carry();
        checkVector("no_carry", 4'b0010, 4'b0111, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_carry_out();
        checkVector("carry_out_1", 4'b1010, 4'b1110, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
        checkVector("carry_out_2", 4'b1110, 4'b1011, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_carry_in();
        checkVector("carry_in_1", 4'b1011, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkVector("carry_in_2", 4'b0101, 4'b1101, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_boundaries();
        checkVector("full_propagate", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
        checkVector("all_ones",       4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
        checkVector("all_zero",       4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Two operand sets on consecutive edges; each result lasts one cycle.
    task automatic test_back_to_back();
        applyStimulus(4'b0011, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        bus.a = 4'b0110;
        bus.b = 4'b1001;
        testsRun++;
        if ({bus.cout, bus.s} !== 5'b1_0010) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got cout=%b s=%b, want cout=1 s=0010", bus.cout, bus.s);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if ({bus.cout, bus.s, bus.grp_p} !== 6'b0_1111_1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got cout=%b s=%b p=%b, want cout=0 s=1111 p=1",
                     bus.cout, bus.s, bus.grp_p);
        end
    endtask

    // Every a, b, cin combination against the bench's own arithmetic.
    task automatic test_exhaustive();
        logic [W:0] full;
        logic [W:0] noCin;
        logic       expP;
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vec;
            vec = v[8:0];
            applyStimulus(vec[3:0], vec[7:4], vec[8]);
            full  = {1'b0, vec[3:0]} + {1'b0, vec[7:4]} + {4'b0, vec[8]};
            noCin = {1'b0, vec[3:0]} + {1'b0, vec[7:4]};
            expP  = &(vec[3:0] ^ vec[7:4]);
            @(posedge clk);
            #1;
            testsRun++;
            if ({bus.cout, bus.s, bus.grp_p, bus.grp_g} !== {full, expP, noCin[W]}) begin
                testsFailed++;
                $display("[TB] FAIL sweep a=%b b=%b cin=%b: got cout=%b s=%b p=%b g=%b, want cout=%b s=%b p=%b g=%b",
                         vec[3:0], vec[7:4], vec[8], bus.cout, bus.s, bus.grp_p, bus.grp_g,
                         full[W], full[W-1:0], expP, noCin[W]);
            end
        end
    endtask

    // Reset dropped between edges while a stream is running.
    task automatic test_mid_reset();
        checkVector("pre_reset", 4'b1001, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0111, 4'b0111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({bus.cout, bus.s, bus.grp_p, bus.grp_g} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_clear: got cout=%b s=%b p=%b g=%b, want all 0",
                     bus.cout, bus.s, bus.grp_p, bus.grp_g);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if ({bus.cout, bus.s} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_hold: got cout=%b s=%b, want 0", bus.cout, bus.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checkVector("post_reset", 4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
    endtask

    // Scenario sequence and summary.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_no_carry();
        test_carry_out();
        test_carry_in();
        test_boundaries();
        test_back_to_back();
        test_exhaustive();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
